// File: rtl/d_ff_pipe_en.sv
// Elastic S-stage register pipeline with valid/ready on both ends, bubble collapse,
// synchronous flush and occupancy count. Define RESET_DATA_EN to reset data registers to RST_VAL.
module d_ff_pipe_en #(
    parameter int           W       = 5,
    parameter int           S       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             D,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             Q,
    output logic [$clog2(S+1)-1:0]   count
);

    localparam int CW = $clog2(S+1);

    // Handshake: a word moves across a boundary on a rising edge only when the sender's
    // valid and the receiver's ready are both 1; valid never depends on ready.
    logic [W-1:0]  data_q [S];
    logic [W-1:0]  data_d [S];
    logic [S-1:0]  valid_q, valid_d;
    logic [S-1:0]  ready;
    logic [CW-1:0] count_q, count_d;
    logic          accept, emit;

    // ready[k] is true when any stage from k to the output is empty, or the sink takes Q.
    always_comb begin
        logic acc;
        acc   = out_ready;
        ready = '0;
        for (int k = S-1; k >= 0; k--) begin
            acc      = ~valid_q[k] | acc;
            ready[k] = acc;
        end
    end

    assign in_ready  = ready[0] & ~flush;
    assign out_valid = valid_q[S-1];
    assign Q         = data_q[S-1];
    assign count     = count_q;
    assign accept    = in_valid & in_ready;
    assign emit      = valid_q[S-1] & out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (ready[0]) begin
                valid_d[0] = accept;
                data_d[0]  = D;
            end
            for (int k = 1; k < S; k++) begin
                if (ready[k]) begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = data_q[k-1];
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({accept, emit})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

`ifdef RESET_DATA_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < S; k++) begin
                data_q[k] <= RST_VAL;
            end
        end else begin
            data_q <= data_d;
        end
    end
`else
    // Data registers carry no reset; RST_VAL only matters in the reset-data build.
    logic unused_rst_val;
    assign unused_rst_val = ^RST_VAL;

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end
`endif

endmodule

// File: tb/tb_d_ff_pipe_en.sv
// Bench for d_ff_pipe_en: directed vectors, an expected-word queue filled on accept,
// and a monitor that pops and compares on every emit.
module tb_d_ff_pipe_en;

    localparam int           W       = 5;
    localparam int           S       = 3;
    localparam int           CW      = $clog2(S+1);
    localparam logic [W-1:0] RST_VAL = 5'b10101;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  D;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Q;
    logic [CW-1:0] count;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_w;
    int            n_checks = 0;
    int            n_errors = 0;

    d_ff_pipe_en #(.W(W), .S(S), .RST_VAL(RST_VAL)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are held from just after one edge to just after the next.
    task automatic cycle();
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(D);
        @(posedge clk);
        #1;
        if (flush) exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_word: got %0h expected no word", Q);
            end else begin
                exp_w = exp_q.pop_front();
                check("out_word", Q, exp_w);
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; D = '0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Streaming
        out_ready = 1'b1; in_valid = 1'b1;
        D = 5'b00001; cycle(); check("stream_cnt1", count, 1); check("stream_ov1", out_valid, 0);
        D = 5'b00010; cycle(); check("stream_cnt2", count, 2); check("stream_ov2", out_valid, 0);
        D = 5'b00011; cycle(); check("stream_cnt3", count, 3); check("stream_ov3", out_valid, 1);
        check("stream_q3", Q, 5'b00001);
        in_valid = 1'b0;
        cycle(); check("stream_cnt4", count, 2);
        cycle(); check("stream_cnt5", count, 1);
        cycle(); check("stream_cnt6", count, 0); check("stream_ov6", out_valid, 0);

        // Back-pressure fill
        out_ready = 1'b0; in_valid = 1'b1;
        D = 5'b11001; #1 check("bp_rdy0", in_ready, 1); cycle();
        D = 5'b11111; cycle();
        D = 5'b00111; cycle();
        check("bp_full_cnt", count, 3);
        D = 5'b01010; #1;
        check("bp_full_rdy", in_ready, 0);
        check("bp_full_ov", out_valid, 1);
        cycle();
        check("bp_hold_cnt", count, 3);
        check("bp_hold_rdy", in_ready, 0);
        out_ready = 1'b1; #1;
        check("bp_open_rdy", in_ready, 1);
        cycle();
        check("bp_swap_cnt", count, 3);
        in_valid = 1'b0;
        repeat (3) cycle();
        check("bp_drain_cnt", count, 0);

        // Bubble collapse
        out_ready = 1'b0; in_valid = 1'b1; D = 5'b11001; cycle();
        in_valid = 1'b0; #1 check("bub_rdy1", in_ready, 1); cycle();
        in_valid = 1'b1; D = 5'b00110; #1 check("bub_rdy2", in_ready, 1); cycle();
        in_valid = 1'b0; cycle();
        check("bub_cnt", count, 2);
        check("bub_rdy", in_ready, 1);
        check("bub_ov", out_valid, 1);
        check("bub_q", Q, 5'b11001);
        in_valid = 1'b1; D = 5'b10000; cycle();
        check("bub_full_cnt", count, 3);
        check("bub_full_rdy", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        check("bub_drain_cnt", count, 0);

        // Flush
        out_ready = 1'b0; in_valid = 1'b1;
        D = 5'b00101; cycle();
        D = 5'b01100; cycle();
        D = 5'b10011; cycle();
        check("fl_pre_cnt", count, 3);
        out_ready = 1'b1; flush = 1'b1; D = 5'b11100; #1;
        check("fl_rdy", in_ready, 0);
        check("fl_ov", out_valid, 1);
        cycle();
        flush = 1'b0; in_valid = 1'b0; #1;
        check("fl_cnt", count, 0);
        check("fl_ov_after", out_valid, 0);
        check("fl_rdy_after", in_ready, 1);
        in_valid = 1'b1; D = 5'b01111; cycle();
        in_valid = 1'b0; cycle(); cycle();
        check("fl_post_ov", out_valid, 1);
        check("fl_post_q", Q, 5'b01111);
        cycle();
        check("fl_post_cnt", count, 0);

        // Simultaneous accept and emit at count 1
        out_ready = 1'b0; in_valid = 1'b1; D = 5'b10001; cycle();
        in_valid = 1'b0; cycle(); cycle();
        check("sim_pre_cnt", count, 1);
        check("sim_pre_ov", out_valid, 1);
        in_valid = 1'b1; D = 5'b01110; out_ready = 1'b1; #1;
        check("sim_rdy", in_ready, 1);
        cycle();
        check("sim_cnt", count, 1);
        in_valid = 1'b0;
        repeat (3) cycle();
        check("sim_drain_cnt", count, 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        D = 5'b00011; cycle();
        D = 5'b11000; cycle();
        in_valid = 1'b0;
        check("ar_pre_cnt", count, 2);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        check("ar_ov", out_valid, 0);
        check("ar_cnt", count, 0);
        check("ar_rdy", in_ready, 1);
`ifdef RESET_DATA_EN
        check("ar_q", Q, RST_VAL);
`endif
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1; in_valid = 1'b1; D = 5'b10110; cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("ar_post_cnt", count, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
